// File: rtl/cpu_pkg.sv
// Shared definitions for the microcoded CPU controller: opcode map,
// sequencer state encoding and the control word bundle.
package cpu_pkg;

   localparam int OPW = 4;

   typedef enum logic [2:0] {
      T0   = 3'd0,
      T1   = 3'd1,
      T2   = 3'd2,
      T3   = 3'd3,
      T4   = 3'd4,
      HALT = 3'd5
   } state_t;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4;
   localparam logic [3:0] OP_OR  = 4'h5;
   localparam logic [3:0] OP_XOR = 4'h6;
   localparam logic [3:0] OP_NOT = 4'h7;
   localparam logic [3:0] OP_JC  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef struct packed {
      logic pc_out;
      logic pc_inc;
      logic pc_load;
      logic mar_load;
      logic ram_out;
      logic ir_load;
      logic ir_out;
      logic a_load;
      logic a_out;
      logic b_load;
      logic alu_out_en;
      logic sub;
      logic out_load;
      logic halted;
   } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational microcode decode: current state, opcode and carry flag
// map to the control word, ALU operation and the next state.
module ctrl_decode
   import cpu_pkg::*;
#(
   parameter int OPW = cpu_pkg::OPW
) (
   input  state_t         state,
   input  logic [OPW-1:0] opcode,
   input  logic           carry,
   output ctrl_t          ctrl,
   output logic [OPW-1:0] alu_op,
   output state_t         next_state
);

   logic is_lda;
   logic is_alu;
   logic is_out;
   logic is_jc;
   logic is_hlt;

   assign is_lda = (opcode == OPW'(OP_LDA));
   assign is_alu = (opcode >= OPW'(OP_ADD)) && (opcode <= OPW'(OP_NOT));
   assign is_out = (opcode == OPW'(OP_OUT));
   assign is_jc  = (opcode == OPW'(OP_JC));
   assign is_hlt = (opcode == OPW'(OP_HLT));

   always_comb begin
      ctrl       = '0;
      alu_op     = '0;
      next_state = state;
      case (state)
         T0: begin
            ctrl.pc_out   = 1'b1;
            ctrl.mar_load = 1'b1;
            next_state    = T1;
         end
         T1: begin
            ctrl.ram_out = 1'b1;
            ctrl.ir_load = 1'b1;
            ctrl.pc_inc  = 1'b1;
            next_state   = T2;
         end
         T2: begin
            next_state = T0;
            if (is_lda || is_alu) begin
               ctrl.ir_out   = 1'b1;
               ctrl.mar_load = 1'b1;
               next_state    = T3;
            end else if (is_out) begin
               ctrl.a_out    = 1'b1;
               ctrl.out_load = 1'b1;
            end else if (is_jc) begin
               ctrl.ir_out  = carry;
               ctrl.pc_load = carry;
            end else if (is_hlt) begin
               next_state = HALT;
            end
         end
         // An opcode that is neither LDA nor ALU here means it changed after T2;
         // abandon the instruction rather than guess an operand destination.
         T3: begin
            next_state = T0;
            if (is_lda) begin
               ctrl.ram_out = 1'b1;
               ctrl.a_load  = 1'b1;
            end else if (is_alu) begin
               ctrl.ram_out = 1'b1;
               ctrl.b_load  = 1'b1;
               next_state   = T4;
            end
         end
         T4: begin
            ctrl.alu_out_en = 1'b1;
            ctrl.a_load     = 1'b1;
            ctrl.sub        = (opcode == OPW'(OP_SUB));
            alu_op          = opcode;
            next_state      = T0;
         end
         HALT: begin
            ctrl.halted = 1'b1;
            next_state  = HALT;
         end
         default: next_state = T0;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Instruction sequencer: owns the state register and carry flag and
// exposes the decoded control word as individual control lines.
module control_sequencer
   import cpu_pkg::*;
#(
   parameter int OPW = cpu_pkg::OPW
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [OPW-1:0] ir_opcode,
   input  logic           alu_cout,
   output logic           pc_out,
   output logic           pc_inc,
   output logic           pc_load,
   output logic           mar_load,
   output logic           ram_out,
   output logic           ir_load,
   output logic           ir_out,
   output logic           a_load,
   output logic           a_out,
   output logic           b_load,
   output logic           alu_out_en,
   output logic           sub,
   output logic           out_load,
   output logic           halted,
   output logic [OPW-1:0] alu_op
);

   state_t state;
   state_t next_state;
   logic   carry;
   ctrl_t  ctrl;

   ctrl_decode #(.OPW(OPW)) u_decode (
      .state      (state),
      .opcode     (ir_opcode),
      .carry      (carry),
      .ctrl       (ctrl),
      .alu_op     (alu_op),
      .next_state (next_state)
   );

   // Carry is captured only as an ALU instruction completes; reset wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= T0;
         carry <= 1'b0;
      end else begin
         if (state == T4) begin
            carry <= alu_cout;
         end
         state <= next_state;
      end
   end

   assign pc_out     = ctrl.pc_out;
   assign pc_inc     = ctrl.pc_inc;
   assign pc_load    = ctrl.pc_load;
   assign mar_load   = ctrl.mar_load;
   assign ram_out    = ctrl.ram_out;
   assign ir_load    = ctrl.ir_load;
   assign ir_out     = ctrl.ir_out;
   assign a_load     = ctrl.a_load;
   assign a_out      = ctrl.a_out;
   assign b_load     = ctrl.b_load;
   assign alu_out_en = ctrl.alu_out_en;
   assign sub        = ctrl.sub;
   assign out_load   = ctrl.out_load;
   assign halted     = ctrl.halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: instruction-level reference model driven by a random
// opcode stream plus directed LDA/SUB/JC/HLT/reset scenarios.
module tb_control_sequencer;

   localparam logic [13:0] PO  = 14'd1 << 13;
   localparam logic [13:0] PI  = 14'd1 << 12;
   localparam logic [13:0] PL  = 14'd1 << 11;
   localparam logic [13:0] ML  = 14'd1 << 10;
   localparam logic [13:0] RO  = 14'd1 << 9;
   localparam logic [13:0] IL  = 14'd1 << 8;
   localparam logic [13:0] IO  = 14'd1 << 7;
   localparam logic [13:0] AL  = 14'd1 << 6;
   localparam logic [13:0] AO  = 14'd1 << 5;
   localparam logic [13:0] BL  = 14'd1 << 4;
   localparam logic [13:0] AOE = 14'd1 << 3;
   localparam logic [13:0] SB  = 14'd1 << 2;
   localparam logic [13:0] OL  = 14'd1 << 1;
   localparam logic [13:0] HL  = 14'd1 << 0;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] ir_opcode = 4'h0;
   logic       alu_cout = 1'b0;
   logic pc_out, pc_inc, pc_load, mar_load, ram_out, ir_load, ir_out;
   logic a_load, a_out, b_load, alu_out_en, sub, out_load, halted;
   logic [3:0] alu_op;
   logic [13:0] act;

   logic [13:0] exp_word  = '0;
   logic [3:0]  exp_aluop = '0;
   logic        exp_valid = 1'b0;
   logic        model_carry = 1'b0;
   int          total = 0;
   int          bad = 0;

   control_sequencer #(.OPW(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .ir_opcode  (ir_opcode),
      .alu_cout   (alu_cout),
      .pc_out     (pc_out),
      .pc_inc     (pc_inc),
      .pc_load    (pc_load),
      .mar_load   (mar_load),
      .ram_out    (ram_out),
      .ir_load    (ir_load),
      .ir_out     (ir_out),
      .a_load     (a_load),
      .a_out      (a_out),
      .b_load     (b_load),
      .alu_out_en (alu_out_en),
      .sub        (sub),
      .out_load   (out_load),
      .halted     (halted),
      .alu_op     (alu_op)
   );

   assign act = {pc_out, pc_inc, pc_load, mar_load, ram_out, ir_load, ir_out,
                 a_load, a_out, b_load, alu_out_en, sub, out_load, halted};

   always #5 clk = ~clk;

   // Instruction length in cycles, straight from the instruction set table.
   function automatic int instr_len(input logic [3:0] op);
      if (op >= 4'h2 && op <= 4'h7) return 5;
      if (op == 4'h1) return 4;
      return 3;
   endfunction

   // Control lines expected in cycle 'step' of an instruction with opcode 'op'.
   function automatic logic [13:0] model_word(input logic [3:0] op, input int step,
                                              input logic carry);
      logic alu_class;
      alu_class = (op >= 4'h2 && op <= 4'h7);
      case (step)
         0: return PO | ML;
         1: return RO | IL | PI;
         2: begin
            if (op == 4'h1 || alu_class) return IO | ML;
            if (op == 4'hE) return AO | OL;
            if (op == 4'h8 && carry) return IO | PL;
            return '0;
         end
         3: return (op == 4'h1) ? (RO | AL) : (RO | BL);
         4: return AOE | AL | ((op == 4'h3) ? SB : 14'd0);
         default: return '0;
      endcase
   endfunction

   always @(negedge clk) begin
      if (exp_valid) begin
         total++;
         if (act !== exp_word) begin
            bad++;
            $display("FAIL controls: got %b want %b", act, exp_word);
         end
         total++;
         if (alu_op !== exp_aluop) begin
            bad++;
            $display("FAIL alu_op: got %h want %h", alu_op, exp_aluop);
         end
         total++;
         if ($countones({pc_out, ram_out, ir_out, a_out, alu_out_en}) > 1) begin
            bad++;
            $display("FAIL bus_drivers: got %b want at most one set",
                     {pc_out, ram_out, ir_out, a_out, alu_out_en});
         end
      end
   end

   task automatic check_lit(input string name, input logic [13:0] got, input logic [13:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // Drive one whole instruction; optionally force alu_cout in the ALU cycle,
   // assert reset in a chosen cycle, and pin one cycle against a literal.
   task automatic run_instr(input logic [3:0] op, input int cout_force, input int rst_step,
                            input int chk_step, input string chk_name,
                            input logic [13:0] chk_mask, input logic [13:0] chk_want,
                            input logic [3:0] chk_aluop);
      int   len;
      logic co;
      len = instr_len(op);
      for (int s = 0; s < len; s++) begin
         ir_opcode = (s < 2) ? 4'($urandom_range(0, 15)) : op;
         co = (cout_force >= 0 && s == 4) ? 1'(cout_force) : 1'($urandom_range(0, 1));
         alu_cout  = co;
         rst       = (s == rst_step);
         exp_word  = model_word(op, s, model_carry);
         exp_aluop = (s == 4) ? op : 4'h0;
         exp_valid = 1'b1;
         if (s == chk_step) begin
            #2;
            check_lit(chk_name, act & chk_mask, chk_want);
            if (s == 4) check_lit({chk_name, "_aluop"}, 14'(alu_op), 14'(chk_aluop));
         end
         @(posedge clk);
         #1;
         if (s == rst_step) begin
            model_carry = 1'b0;
            rst = 1'b0;
            return;
         end
         if (s == 4) model_carry = co;
      end
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] op;
      int         rs;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #2;
      check_lit("reset_word", act, PO | ML);
      check_lit("reset_aluop", 14'(alu_op), 14'd0);

      run_instr(4'h1, -1, -1, 3, "lda_t3", RO | AL, RO | AL, 4'h0);
      run_instr(4'hB, -1, -1, 0, "lda_back_t0", PO | ML, PO | ML, 4'h0);
      run_instr(4'h0, -1, -1, 0, "nop_b_len", PO | ML, PO | ML, 4'h0);

      run_instr(4'h3, 1, -1, 4, "sub_t4", AOE | SB, AOE | SB, 4'h3);
      run_instr(4'h8, -1, -1, 2, "jc_after_sub", PL, PL, 4'h0);

      run_instr(4'h2, 1, -1, -1, "", '0, '0, 4'h0);
      run_instr(4'h8, -1, -1, 2, "jc_taken", PL | IO, PL | IO, 4'h0);
      run_instr(4'h2, 0, -1, -1, "", '0, '0, 4'h0);
      run_instr(4'h8, -1, -1, 2, "jc_not_taken", PL | IO, 14'd0, 4'h0);

      run_instr(4'h2, 1, -1, -1, "", '0, '0, 4'h0);
      run_instr(4'h6, 1, 4, -1, "", '0, '0, 4'h0);
      run_instr(4'h8, -1, -1, 0, "xor_rst_t0", PO | ML, PO | ML, 4'h0);
      run_instr(4'h8, -1, -1, 2, "xor_rst_carry", PL, 14'd0, 4'h0);

      for (int n = 0; n < 300; n++) begin
         op = 4'($urandom_range(0, 14));
         rs = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, instr_len(op) - 1)) : -1;
         run_instr(op, -1, rs, -1, "", '0, '0, 4'h0);
      end

      run_instr(4'hF, -1, -1, -1, "", '0, '0, 4'h0);
      for (int i = 0; i < 20; i++) begin
         ir_opcode = 4'($urandom_range(0, 15));
         alu_cout  = 1'($urandom_range(0, 1));
         exp_word  = HL;
         exp_aluop = 4'h0;
         if (i == 0) begin
            #2;
            check_lit("halt_cycle4", act, HL);
         end
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_carry = 1'b0;
      #2;
      check_lit("halt_release", act, PO | ML);
      run_instr(4'h8, -1, -1, 2, "carry_after_halt", PL, 14'd0, 4'h0);

      exp_valid = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
